uart_ctrl: RTL and testbench

UART peripheral behind the CSR unit's MUARTSTAT (0xFC0), MUARTRX (0xFC1) and MUARTTX (0x7C0) registers.
- Accepts single-cycle register requests from the CSR unit and returns a registered response one cycle later, in the same shape as the BFS CSR port.
- Buffers transmit and receive bytes in FIFOs.
- Drives and samples an 8N1 serial line.

---
 rtl/uart_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// Circular byte FIFO with (log2 DEPTH)+1-bit pointers; head data is combinational.
// Zero-latency pop view; push visible on the next cycle.
// Push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // a full FIFO hands its head slot to a simultaneous push
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// UART peripheral for the CSR unit: STAT/RX/TX registers, TX/RX byte FIFOs, 8N1 line.
// CSR response registered one cycle after the request; TX line falls two cycles after a write.
// Never stalls: full TX FIFO rejects writes with error, full RX FIFO drops bytes and flags overrun.
module uart_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_uart_valid,
    input  logic [1:0]  csr_uart_addr,
    input  logic        csr_uart_wen,
    input  logic [7:0]  csr_uart_wdata,
    output logic        uart_csr_valid,
    output logic        uart_csr_error,
    output logic [31:0] uart_csr_rdata,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    typedef struct packed {
        logic frame_err;
        logic rx_overrun;
        logic tx_full;
        logic tx_empty;
        logic rx_full;
        logic rx_empty;
    } stat_t;

    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_pop_dat;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  rx_pop_dat;
    logic        rx_overrun, frame_err, ovr_set, ferr_set, stat_clr;
    logic [7:0]  tx_last;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    stat_t       stat;

    assign stat = {frame_err, rx_overrun, tx_full, tx_empty, rx_full, rx_empty};

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_dat(csr_uart_wdata),
        .pop(tx_pop), .pop_dat(tx_pop_dat), .empty(tx_empty), .full(tx_full)
    );

    always_comb begin
        rsp_err  = 1'b0;
        rsp_dat  = '0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        stat_clr = 1'b0;
        if (csr_uart_valid) begin
            case (csr_uart_addr)
                2'd0: begin
                    if (csr_uart_wen) rsp_err = 1'b1;
                    else begin
                        rsp_dat  = {26'd0, stat};
                        stat_clr = 1'b1;
                    end
                end
                2'd1: begin
                    if (csr_uart_wen || rx_empty) rsp_err = 1'b1;
                    else begin
                        rsp_dat = {24'd0, rx_pop_dat};
                        rx_pop  = 1'b1;
                    end
                end
                2'd2: begin
                    if (!csr_uart_wen) rsp_dat = {24'd0, tx_last};
                    else if (tx_full)  rsp_err = 1'b1;
                    else               tx_push = 1'b1;
                end
                default: rsp_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_csr_valid <= 1'b0;
            uart_csr_error <= 1'b0;
            uart_csr_rdata <= '0;
            tx_last        <= '0;
            rx_overrun     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            uart_csr_valid <= csr_uart_valid;
            uart_csr_error <= rsp_err;
            uart_csr_rdata <= rsp_dat;
            if (tx_push) tx_last <= csr_uart_wdata;
            // a fresh event wins over the clearing STAT read
            rx_overrun <= (rx_overrun && !stat_clr) || ovr_set;
            frame_err  <= (frame_err && !stat_clr) || ferr_set;
        end
    end

    uart_state_t tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          txd_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_txd <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CNT_ONE;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        txd_n      = uart_txd;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_pop_dat;
                    tx_state_n = START;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = DATA;
                    txd_n      = tx_shift[0];
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                        txd_n    = tx_shift[tx_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    // back-to-back frames: next start bit follows the stop bit directly
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_pop_dat;
                        tx_state_n = START;
                        txd_n      = 1'b0;
                    end else begin
                        tx_state_n = IDLE;
                        txd_n      = 1'b1;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    uart_state_t rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [1:0]    rx_sync;
    logic          rxd_s, rxd_prev;

    assign rxd_s = rx_sync[1];

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_dat(rx_shift),
        .pop(rx_pop), .pop_dat(rx_pop_dat), .empty(rx_empty), .full(rx_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rxd_prev <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rxd};
            rxd_prev <= rxd_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    // rx_cnt holds the offset from the previous sample point (or from the falling edge)
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CNT_ONE;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = CNT_ONE;
                if (rxd_prev && !rxd_s) rx_state_n = START;
            end
            START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_n   = CNT_ONE;
                    rx_idx_n   = '0;
                    rx_state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_FULL) begin
                    rx_cnt_n   = CNT_ONE;
                    rx_shift_n = {rxd_s, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_FULL) begin
                    rx_state_n = IDLE;
                    if (!rxd_s)                  ferr_set = 1'b1;
                    else if (rx_full && !rx_pop) ovr_set  = 1'b1;
                    else                         rx_push  = 1'b1;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Randomized scoreboard bench for uart_ctrl: a cycle-level behavioural model predicts CSR
// responses and TX frames; independent monitors compare them against the DUT outputs.
module tb_uart_ctrl;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_uart_valid = 1'b0;
    logic [1:0]  csr_uart_addr = '0;
    logic        csr_uart_wen = 1'b0;
    logic [7:0]  csr_uart_wdata = '0;
    logic        uart_csr_valid;
    logic        uart_csr_error;
    logic [31:0] uart_csr_rdata;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    uart_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .csr_uart_valid(csr_uart_valid), .csr_uart_addr(csr_uart_addr),
        .csr_uart_wen(csr_uart_wen), .csr_uart_wdata(csr_uart_wdata),
        .uart_csr_valid(uart_csr_valid), .uart_csr_error(uart_csr_error),
        .uart_csr_rdata(uart_csr_rdata),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    typedef struct packed { int c; logic err; logic [31:0] rd; } rsp_t;
    typedef struct packed { int c; logic [7:0] b; } txf_t;
    typedef struct packed { int c; logic [7:0] b; logic ok; } rxe_t;

    rsp_t       rsp_q[$];
    txf_t       exp_tx[$];
    rxe_t       rx_evt[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       rx_line[$];
    int         tx_free = 0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] m_last = '0;

    // Model one clock cycle: request sees state at the start of the cycle, then that cycle's
    // transmitter pop, request side effects and any receive completion are applied.
    task automatic step(input logic v, input logic [1:0] a, input logic w, input logic [7:0] d);
        logic [31:0] stat, rd;
        logic err, tx_pop, tx_push, rx_pop, clr;
        rxe_t ev;
        uart_rxd = (rx_line.size() > 0) ? rx_line.pop_front() : 1'b1;
        stat = {26'd0, m_ferr, m_ovr, (tx_q.size() == DEPTH), (tx_q.size() == 0),
                (rx_q.size() == DEPTH), (rx_q.size() == 0)};
        tx_pop = (tx_q.size() > 0) && (cyc >= tx_free);
        err = 1'b0; rd = '0; tx_push = 1'b0; rx_pop = 1'b0; clr = 1'b0;
        if (v) begin
            case (a)
                2'd0: if (w) err = 1'b1; else begin rd = stat; clr = 1'b1; end
                2'd1: if (w || rx_q.size() == 0) err = 1'b1;
                      else begin rd = {24'd0, rx_q[0]}; rx_pop = 1'b1; end
                2'd2: if (!w) rd = {24'd0, m_last};
                      else if (tx_q.size() == DEPTH) err = 1'b1;
                      else tx_push = 1'b1;
                default: err = 1'b1;
            endcase
            rsp_q.push_back('{c: cyc + 1, err: err, rd: rd});
        end
        if (tx_pop) begin
            exp_tx.push_back('{c: cyc + 1, b: tx_q.pop_front()});
            tx_free = cyc + FRAME;
        end
        if (tx_push) begin tx_q.push_back(d); m_last = d; end
        if (rx_pop) void'(rx_q.pop_front());
        if (clr) begin m_ovr = 1'b0; m_ferr = 1'b0; end
        if (rx_evt.size() > 0 && rx_evt[0].c == cyc) begin
            ev = rx_evt.pop_front();
            if (!ev.ok)                    m_ferr = 1'b1;
            else if (rx_q.size() == DEPTH) m_ovr  = 1'b1;
            else                           rx_q.push_back(ev.b);
        end
        csr_uart_valid = v;
        csr_uart_addr  = a;
        csr_uart_wen   = w;
        csr_uart_wdata = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 1'b0, 8'd0);
    endtask

    // Stop sample lands 2 sync cycles plus 9.5 bit times after the start bit is driven.
    function automatic void send_rx(input logic [7:0] b, input logic ok);
        int t0 = cyc + rx_line.size();
        for (int i = 0; i < CPB; i++) rx_line.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CPB; i++) rx_line.push_back(b[k]);
        for (int i = 0; i < CPB; i++) rx_line.push_back(ok);
        for (int i = 0; i < CPB; i++) rx_line.push_back(1'b1);
        rx_evt.push_back('{c: t0 + 2 + CPB / 2 + 9 * CPB, b: b, ok: ok});
    endfunction

    function automatic void send_glitch();
        for (int i = 0; i < 4; i++) rx_line.push_back(1'b0);
        for (int i = 0; i < CPB; i++) rx_line.push_back(1'b1);
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        csr_uart_valid = 1'b0;
        uart_rxd = 1'b1;
        #1 check("rst_txd_immediate", uart_txd, 1);
        tx_q.delete(); rx_q.delete(); rx_line.delete(); rx_evt.delete();
        exp_tx.delete(); rsp_q.delete();
        tx_free = 0; m_ovr = 1'b0; m_ferr = 1'b0; m_last = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // CSR response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_csr_valid", uart_csr_valid, 0);
                check("rst_csr_error", uart_csr_error, 0);
                check("rst_csr_rdata", uart_csr_rdata, 0);
            end else begin
                while (rsp_q.size() > 0 && rsp_q[0].c < cyc) begin
                    check("rsp_missing_due_cycle", cyc, rsp_q[0].c);
                    void'(rsp_q.pop_front());
                end
                if (uart_csr_valid) begin
                    if (rsp_q.size() == 0) check("rsp_unexpected", uart_csr_valid, 0);
                    else begin
                        e = rsp_q.pop_front();
                        check("rsp_cycle", cyc, e.c);
                        check("rsp_error", uart_csr_error, e.err);
                        check("rsp_rdata", uart_csr_rdata, e.rd);
                    end
                end else begin
                    check("idle_rdata", uart_csr_rdata, 0);
                end
            end
        end
    end

    // TX line monitor: decodes frames at bit centres
    initial begin
        bit         in_fr = 1'b0;
        int         fs = 0;
        int         off;
        logic [7:0] got = '0;
        logic [7:0] want = '0;
        txf_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_fr = 1'b0;
                check("rst_txd", uart_txd, 1);
            end else if (!in_fr) begin
                if (uart_txd == 1'b0) begin
                    in_fr = 1'b1;
                    fs = cyc;
                    if (exp_tx.size() == 0) check("tx_unexpected_frame", uart_txd, 1);
                    else begin
                        e = exp_tx.pop_front();
                        check("tx_start_cycle", cyc, e.c);
                        want = e.b;
                    end
                end
            end else begin
                off = cyc - fs;
                if (off == CPB / 2) check("tx_start_bit", uart_txd, 0);
                for (int k = 0; k < 8; k++)
                    if (off == CPB / 2 + (k + 1) * CPB) got[k] = uart_txd;
                if (off == CPB / 2 + 9 * CPB) begin
                    check("tx_stop_bit", uart_txd, 1);
                    check("tx_byte", got, want);
                end
                if (off == FRAME - 1) in_fr = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(1, 2'd0, 0, 8'h00);                  // STAT after reset
        idle(2);

        step(1, 2'd2, 1, 8'hA5);                  // single TX frame
        idle(FRAME + 10);
        step(1, 2'd2, 0, 8'h00);                  // TX readback

        for (int i = 0; i < 9; i++) step(1, 2'd2, 1, 8'(8'h10 + i));
        step(1, 2'd0, 0, 8'h00);                  // TXFULL
        step(1, 2'd2, 1, 8'hEE);                  // rejected
        idle(9 * FRAME + 20);

        send_rx(8'h3C, 1'b1);
        idle(FRAME + 2 * CPB);
        step(1, 2'd0, 0, 8'h00);
        step(1, 2'd1, 0, 8'h00);
        step(1, 2'd1, 0, 8'h00);                  // empty -> error

        for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
        idle(9 * (FRAME + CPB) + 20);
        step(1, 2'd2, 1, 8'h5A);
        step(1, 2'd2, 1, 8'hC3);
        step(1, 2'd0, 0, 8'h00);                  // RXFULL|RXOVERRUN
        step(1, 2'd0, 0, 8'h00);                  // overrun cleared
        for (int i = 0; i < 9; i++) step(1, 2'd1, 0, 8'h00);
        step(1, 2'd0, 1, 8'hFF);                  // illegal writes / reserved
        step(1, 2'd1, 1, 8'hFF);
        step(1, 2'd3, 0, 8'h00);
        idle(2 * FRAME + 20);

        send_rx(8'h55, 1'b0);                     // framing error
        idle(FRAME + 2 * CPB);
        step(1, 2'd0, 0, 8'h00);
        step(1, 2'd0, 0, 8'h00);

        send_glitch();
        idle(3 * CPB);
        step(1, 2'd0, 0, 8'h00);
        send_rx(8'h81, 1'b1);
        idle(FRAME + 2 * CPB);
        step(1, 2'd1, 0, 8'h00);

        step(1, 2'd2, 1, 8'h00);                  // reset in mid frame
        idle(40);
        do_reset(3);
        step(1, 2'd0, 0, 8'h00);
        step(1, 2'd2, 0, 8'h00);

        for (int n = 0; n < 4000; n++) begin
            if (rx_line.size() == 0 && $urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 9) == 0) send_glitch();
                else send_rx(8'($urandom), ($urandom_range(0, 9) != 0));
            end
            if ($urandom_range(0, 99) < 25)
                step(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
            else
                idle(1);
        end

        idle(rx_line.size() + 20);
        guard = 0;
        while (tx_q.size() > 0 && guard < DEPTH + 2) begin
            idle(FRAME);
            guard++;
        end
        idle(FRAME + 20);
        check("tx_model_drained", tx_q.size(), 0);
        check("tx_frames_pending", exp_tx.size(), 0);
        check("rsp_pending", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
